// File: rtl/aes_ctr_ctrl.sv
// Purpose : command sequencer that drives an external AES-CTR core (key, IV, data) and buffers its results.
// Latency : one cycle from an accepted din beat to the core result, plus at least one cycle through the skid FIFO to m_data_o.
// Backpressure: m_ready_i low fills the 4-entry skid FIFO; dout_ready_o, din_valid_o and s_ready_o then drop until it drains.
//
// Ports: clk/rst_n (async active-low); cmd_* command handshake (key, IV, length in blocks, key reuse);
//        s_* input block stream; m_* output block stream with m_last_o; key_*/iv_*/din_*/dout_* core side;
//        busy_o outside IDLE, done_o one-cycle pulse when a command completes.
module aes_ctr_ctrl #(
    parameter int KEY_SIZE = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_SIZE-1:0] cmd_key_i,
    input  logic [127:0]        cmd_iv_i,
    input  logic [15:0]         cmd_len_i,
    input  logic                cmd_key_reuse_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [127:0]        s_data_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    output logic [127:0]        m_data_o,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic                m_last_o,
    output logic [KEY_SIZE-1:0] key_o,
    output logic                key_valid_o,
    input  logic                key_ready_i,
    output logic [127:0]        iv_o,
    output logic                iv_valid_o,
    output logic [127:0]        din_o,
    output logic                din_valid_o,
    input  logic                din_ready_i,
    input  logic [127:0]        dout_i,
    input  logic                dout_valid_i,
    output logic                dout_ready_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_KWAIT, S_IV, S_STREAM, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [127:0]        iv_q, iv_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         in_cnt_q, in_cnt_d;
    logic [15:0]         out_cnt_q, out_cnt_d;
    logic                key_loaded_q, key_loaded_d;
    logic                kwait_first_q, kwait_first_d;

    // Skid FIFO: storage is not reset, only pointers and count are.
    logic [127:0]        fifo_dat_q [4];
    logic [3:0]          fifo_last_q;
    logic [1:0]          fifo_wr_q, fifo_wr_d;
    logic [1:0]          fifo_rd_q, fifo_rd_d;
    logic [2:0]          fifo_cnt_q, fifo_cnt_d;

    logic                fifo_push, fifo_pop, push_last;
    logic                stream_ok, din_fire;

    // The core cannot be stalled once a beat is in flight, so din is only
    // offered while at least two FIFO slots remain: one for the beat
    // already in flight and one for the beat issued this cycle.
    assign dout_ready_o = (state_q == S_STREAM) && (fifo_cnt_q <= 3'd2);
    assign stream_ok    = (state_q == S_STREAM) && (in_cnt_q < len_q) && dout_ready_o;
    assign din_valid_o  = stream_ok && s_valid_i;
    assign s_ready_o    = stream_ok && din_ready_i;
    assign din_o        = (state_q == S_STREAM) ? s_data_i : 128'd0;
    assign din_fire     = din_valid_o && din_ready_i;

    assign fifo_push = dout_valid_i && ((state_q == S_STREAM) || (state_q == S_DRAIN));
    assign push_last = (out_cnt_q == (len_q - 16'd1));
    assign m_valid_o = (fifo_cnt_q != 3'd0);
    assign fifo_pop  = m_valid_o && m_ready_i;
    assign m_data_o  = m_valid_o ? fifo_dat_q[fifo_rd_q] : 128'd0;
    assign m_last_o  = m_valid_o && fifo_last_q[fifo_rd_q];

    assign busy_o = (state_q != S_IDLE);
    assign key_o  = (state_q != S_IDLE) ? key_q : '0;
    assign iv_o   = (state_q != S_IDLE) ? iv_q : 128'd0;

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        iv_d          = iv_q;
        len_d         = len_q;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        key_loaded_d  = key_loaded_q;
        kwait_first_d = kwait_first_q;
        cmd_ready_o   = 1'b0;
        key_valid_o   = 1'b0;
        iv_valid_o    = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    key_d     = cmd_key_i;
                    iv_d      = cmd_iv_i;
                    len_d     = cmd_len_i;
                    in_cnt_d  = 16'd0;
                    out_cnt_d = 16'd0;
                    if (cmd_len_i == 16'd0) begin
                        state_d = S_DRAIN;
                    end else if (cmd_key_reuse_i && key_loaded_q) begin
                        state_d = S_IV;
                    end else begin
                        state_d = S_KEY;
                    end
                end
            end
            S_KEY: begin
                // Key is presented only in the cycle the core can take it.
                if (key_ready_i) begin
                    key_valid_o   = 1'b1;
                    kwait_first_d = 1'b1;
                    state_d       = S_KWAIT;
                end
            end
            S_KWAIT: begin
                // key_ready_i in the first cycle still reflects the handshake
                // cycle, so expansion completion is only trusted afterwards.
                if (kwait_first_q) begin
                    kwait_first_d = 1'b0;
                end else if (key_ready_i) begin
                    key_loaded_d = 1'b1;
                    state_d      = S_IV;
                end
            end
            S_IV: begin
                iv_valid_o = 1'b1;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                if (in_cnt_q == len_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((out_cnt_q == len_q) && (fifo_cnt_q == 3'd0)) begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (din_fire) begin
            in_cnt_d = in_cnt_q + 16'd1;
        end
        if (fifo_push && (out_cnt_q != 16'hFFFF)) begin
            out_cnt_d = out_cnt_q + 16'd1;
        end
    end

    always_comb begin
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_push) begin
            fifo_wr_d = fifo_wr_q + 2'd1;
        end
        if (fifo_pop) begin
            fifo_rd_d = fifo_rd_q + 2'd1;
        end
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            key_q         <= '0;
            iv_q          <= 128'd0;
            len_q         <= 16'd0;
            in_cnt_q      <= 16'd0;
            out_cnt_q     <= 16'd0;
            key_loaded_q  <= 1'b0;
            kwait_first_q <= 1'b0;
            fifo_wr_q     <= 2'd0;
            fifo_rd_q     <= 2'd0;
            fifo_cnt_q    <= 3'd0;
            fifo_last_q   <= 4'd0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            iv_q          <= iv_d;
            len_q         <= len_d;
            in_cnt_q      <= in_cnt_d;
            out_cnt_q     <= out_cnt_d;
            key_loaded_q  <= key_loaded_d;
            kwait_first_q <= kwait_first_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
            if (fifo_push) begin
                fifo_last_q[fifo_wr_q] <= push_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_dat_q[fifo_wr_q] <= dout_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && (fifo_cnt_q == 3'd4)));
    a_key_iv_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(key_valid_o && iv_valid_o));

endmodule

// File: doc/aes_ctr_ctrl.md
AES_CTR_CTRL -- requirements
Module: aes_ctr_ctrl

Interface
REQ-001 Parameter KEY_SIZE, default from define.svh (128/192/256), width of cmd_key_i and key_o.
REQ-002 Ports, clock and reset first:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_key_i  in  KEY_SIZE  command key.
- cmd_iv_i  in  128  initial counter block.
- cmd_len_i  in  16  message length in 128-bit blocks.
- cmd_key_reuse_i  in  1  skip key expansion, keep loaded key.
- cmd_valid_i/cmd_ready_o  in/out  1  command handshake.
- s_data_i  in  128  plaintext/ciphertext block.
- s_valid_i/s_ready_o  in/out  1  input stream handshake.
- m_data_o  out  128  result block.
- m_valid_o/m_ready_i  out/in  1  output stream handshake.
- m_last_o  out  1  final block of command.
- key_o/key_valid_o/key_ready_i  out/out/in  KEY_SIZE/1/1  core key port.
- iv_o/iv_valid_o  out/out  128/1  core IV port.
- din_o/din_valid_o/din_ready_i  out/out/in  128/1/1  core data-in.
- dout_i/dout_valid_i/dout_ready_o  in/in/out  128/1/1  core data-out.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse on command completion.

Function
REQ-003 Block is the initiator driving the AES-CTR core ports; the core pulses dout_valid_i exactly one cycle after each accepted din beat and does not hold it.
REQ-004 FSM states: IDLE, KEY, KWAIT, IV, STREAM, DRAIN.
REQ-005 IDLE: cmd_ready_o=1; on cmd_valid_i, latch key, IV, len, clear in_cnt/out_cnt.
- len==0: next DRAIN.
- reuse && key_loaded: next IV.
- otherwise: next KEY.
REQ-006 KEY: key_valid_o=1 for exactly the first cycle with key_ready_i=1, then KWAIT; key_o=latched key whenever not IDLE.
REQ-007 KWAIT: ignore key_ready_i for the first cycle, then go to IV on first key_ready_i=1; set key_loaded.
REQ-008 IV: iv_valid_o=1 for exactly one cycle, iv_o=latched IV; next STREAM.
REQ-009 STREAM: din_valid_o = s_valid_i && in_cnt<len; s_ready_o = din_ready_i && in_cnt<len; din_o=s_data_i (combinational pass-through); in_cnt++ per din_valid_o&&din_ready_i; go to DRAIN when in_cnt==len.
REQ-010 dout_ready_o=1 only in STREAM when skid count<=2; skid FIFO depth 4 (registered count) absorbs in-flight beats.
REQ-011 Every dout_valid_i beat in STREAM or DRAIN is pushed to skid FIFO and increments out_cnt (16-bit, no wrap).
REQ-012 m_valid_o = FIFO not empty; m_data_o = FIFO head; pop on m_valid_o&&m_ready_i; m_last_o=1 on the head entry tagged as beat number len-1.
REQ-013 DRAIN: exit to IDLE when out_cnt==len and FIFO empty and no pop pending; done_o pulses in the transition cycle.
REQ-014 Simultaneous push and pop on the FIFO keeps count unchanged; push when count==4 is an illegal condition, flagged by an assertion.
REQ-015 key_valid_o and iv_valid_o are never high in the same cycle, and neither is high outside KEY/IV.
REQ-016 cmd_valid_i outside IDLE is ignored (cmd_ready_o=0).

Reset
REQ-017 rst_n low asynchronously forces IDLE, clears counters, FIFO, key_loaded, busy_o, done_o.
REQ-018 During reset, all *_valid_o, dout_ready_o, s_ready_o and m_last_o are 0; data outputs are 0.
REQ-019 Reset mid-command discards all state; the next command with reuse=1 performs a full key load.

Verification
REQ-020 Len 1 scenario:
- Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, IV f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, len 1, s_data 6bc1bee22e409f96e93d7e117393172a.
- Required response: m_data 874d6191b620e3261bef6864990db6ce, m_last_o=1, one done_o pulse.
REQ-021 Same key, len 4, SP800-38A F.5.1 plaintexts:
- Required response: four F.5.1 ciphertexts in order; last block 1e031dda2fbe03d1792170a0f3009cee with m_last_o.
REQ-022 Second command with reuse=1, same IV, F.5.1 data: same outputs, and key_valid_o never asserts.
REQ-023 len 4 with m_ready_i low for 20 cycles mid-stream:
- Skid count never exceeds 4.
- No beat is lost or duplicated.
- din stalls while dout_ready_o=0.
REQ-024 len 0 -> done_o pulses, no key/IV/din activity; rst_n pulse during STREAM -> all outputs 0, busy_o=0 next cycle.
